// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle for the multi-cycle ALU.
// The control unit drives the master side; the ALU is the slave.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] alu_result_hi;
    logic             zero_flag;
    logic             negative_flag;
    logic             carry_flag;
    logic             overflow_flag;
    logic             div_by_zero;
    logic             illegal_op;

    modport master (
        output start, alu_control, srca, srcb,
        input  ready, done, alu_result, alu_result_hi,
        input  zero_flag, negative_flag, carry_flag,
        input  overflow_flag, div_by_zero, illegal_op
    );

    modport slave (
        input  start, alu_control, srca, srcb,
        output ready, done, alu_result, alu_result_hi,
        output zero_flag, negative_flag, carry_flag,
        output overflow_flag, div_by_zero, illegal_op
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative
// shift-add MUL and restoring DIVU with a start/ready/done handshake.
module seq_alu #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_XOR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_DIVU = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE,
        MUL_RUN,
        DIV_RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] wk_hi;
    logic [WIDTH-1:0] wk_lo;
    logic             last;

    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             z_q;
    logic             n_q;
    logic             c_q;
    logic             v_q;
    logic             dz_q;
    logic             ill_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] sc_lo;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_c;
    logic             sc_v;
    logic             sc_dz;
    logic             sc_ill;

    logic [WIDTH:0]     mul_acc;
    logic [2*WIDTH-1:0] mul_nx;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_tr;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;

    logic             load;
    logic [WIDTH-1:0] fin_lo;
    logic [WIDTH-1:0] fin_hi;
    logic             fin_c;
    logic             fin_v;
    logic             fin_dz;
    logic             fin_ill;

    assign last = (cnt == CNT_W'(WIDTH - 1));

    assign sum  = {1'b0, bus.srca} + {1'b0, bus.srcb};
    assign diff = {1'b0, bus.srca} - {1'b0, bus.srcb};

    // Product register: wk_hi accumulates, wk_lo holds the multiplier
    assign mul_acc = {1'b0, wk_hi} + (wk_lo[0] ? {1'b0, a_q} : '0);
    assign mul_nx  = {mul_acc, wk_lo[WIDTH-1:1]};

    // Remainder stays below the divisor, so the borrow bit decides
    assign div_sh  = {wk_hi, wk_lo[WIDTH-1]};
    assign div_tr  = div_sh - {1'b0, b_q};
    assign div_ge  = ~div_tr[WIDTH];
    assign div_rem = div_ge ? div_tr[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_quo = {wk_lo[WIDTH-2:0], div_ge};

    always_comb begin
        sc_lo  = '0;
        sc_hi  = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_dz  = 1'b0;
        sc_ill = 1'b0;
        unique case (bus.alu_control)
            OP_AND: sc_lo = bus.srca & bus.srcb;
            OP_XOR: sc_lo = bus.srca ^ bus.srcb;
            OP_OR:  sc_lo = bus.srca | bus.srcb;
            OP_NOR: sc_lo = ~(bus.srca | bus.srcb);
            OP_ADD: begin
                sc_lo = sum[WIDTH-1:0];
                sc_c  = sum[WIDTH];
                sc_v  = (bus.srca[WIDTH-1] == bus.srcb[WIDTH-1])
                     && (sum[WIDTH-1] != bus.srca[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo = diff[WIDTH-1:0];
                sc_c  = diff[WIDTH];
                sc_v  = (bus.srca[WIDTH-1] != bus.srcb[WIDTH-1])
                     && (diff[WIDTH-1] != bus.srca[WIDTH-1]);
            end
            OP_SLT: begin
                sc_lo[0] = $signed(bus.srca) < $signed(bus.srcb);
            end
            OP_SLTU: sc_lo[0] = bus.srca < bus.srcb;
            OP_MUL:  sc_lo = '0;
            // Only reached as a single-cycle op when the divisor is 0
            OP_DIVU: begin
                sc_lo = '1;
                sc_hi = bus.srca;
                sc_dz = 1'b1;
            end
            default: sc_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        fin_lo   = sc_lo;
        fin_hi   = sc_hi;
        fin_c    = sc_c;
        fin_v    = sc_v;
        fin_dz   = sc_dz;
        fin_ill  = sc_ill;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.alu_control == OP_MUL) begin
                        state_nx = MUL_RUN;
                    end else if (bus.alu_control == OP_DIVU
                                 && bus.srcb != '0) begin
                        state_nx = DIV_RUN;
                    end else begin
                        state_nx = DONE;
                        load     = 1'b1;
                    end
                end
            end
            MUL_RUN: begin
                fin_lo  = mul_nx[WIDTH-1:0];
                fin_hi  = mul_nx[2*WIDTH-1:WIDTH];
                fin_c   = 1'b0;
                fin_v   = 1'b0;
                fin_dz  = 1'b0;
                fin_ill = 1'b0;
                if (last) begin
                    state_nx = DONE;
                    load     = 1'b1;
                end
            end
            DIV_RUN: begin
                fin_lo  = div_quo;
                fin_hi  = div_rem;
                fin_c   = 1'b0;
                fin_v   = 1'b0;
                fin_dz  = 1'b0;
                fin_ill = 1'b0;
                if (last) begin
                    state_nx = DONE;
                    load     = 1'b1;
                end
            end
            DONE: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            wk_hi  <= '0;
            wk_lo  <= '0;
            res_lo <= '0;
            res_hi <= '0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
            dz_q   <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                a_q   <= bus.srca;
                b_q   <= bus.srcb;
                cnt   <= '0;
                wk_hi <= '0;
                wk_lo <= (bus.alu_control == OP_MUL)
                       ? bus.srcb : bus.srca;
            end else if (state == MUL_RUN) begin
                wk_hi <= mul_nx[2*WIDTH-1:WIDTH];
                wk_lo <= mul_nx[WIDTH-1:0];
                cnt   <= cnt + CNT_W'(1);
            end else if (state == DIV_RUN) begin
                wk_hi <= div_rem;
                wk_lo <= div_quo;
                cnt   <= cnt + CNT_W'(1);
            end
            // Results hold until the next op completes
            if (load) begin
                res_lo <= fin_lo;
                res_hi <= fin_hi;
                z_q    <= (fin_lo == '0);
                n_q    <= fin_lo[WIDTH-1];
                c_q    <= fin_c;
                v_q    <= fin_v;
                dz_q   <= fin_dz;
                ill_q  <= fin_ill;
            end
        end
    end

    assign bus.ready         = (state == IDLE);
    assign bus.done          = (state == DONE);
    assign bus.alu_result    = res_lo;
    assign bus.alu_result_hi = res_hi;
    assign bus.zero_flag     = z_q;
    assign bus.negative_flag = n_q;
    assign bus.carry_flag    = c_q;
    assign bus.overflow_flag = v_q;
    assign bus.div_by_zero   = dz_q;
    assign bus.illegal_op    = ill_q;

endmodule
